// File: rtl/rst_gen_pkg.sv
// rtl/rst_gen_pkg.sv - shared state encoding for the reset pulse generator
package rst_gen_pkg;

    typedef enum logic [2:0] {
        POR,
        IDLE,
        DEBOUNCE,
        PULSE,
        RELEASE
    } rst_gen_state_t;

endpackage

// File: rtl/btn_synchronizer.sv
// rtl/btn_synchronizer.sv - two-flop synchronizer for the asynchronous push-button
module btn_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_sync
);

    logic btn_meta;

    cmn_Reg #(.p_width(1)) u_stage1 (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_meta)
    );

    cmn_Reg #(.p_width(1)) u_stage2 (
        .clk   (clk),
        .reset (reset),
        .d     (btn_meta),
        .q     (btn_sync)
    );

endmodule

// File: rtl/cmn_reg.sv
// rtl/cmn_reg.sv - generic register stage with synchronous active-high clear
module cmn_Reg #(
    parameter int p_width = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [p_width-1:0] d,
    output logic [p_width-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/reset_pulse_gen.sv
// rtl/reset_pulse_gen.sv - power-on reset plus debounced push-button reset pulses
module reset_pulse_gen
    import rst_gen_pkg::*;
#(
    parameter int p_por_cycles      = 32,
    parameter int p_debounce_cycles = 16,
    parameter int p_pulse_cycles    = 8,
    parameter int p_cnt_nbits       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_in,
    output logic                   reset_out,
    output logic                   ready,
    output logic [p_cnt_nbits-1:0] pulse_count
);

    localparam int max_pd    = (p_por_cycles > p_debounce_cycles) ? p_por_cycles : p_debounce_cycles;
    localparam int max_cyc   = (max_pd > p_pulse_cycles) ? max_pd : p_pulse_cycles;
    localparam int cnt_nbits = $clog2(max_cyc) + 1;

    localparam logic [cnt_nbits-1:0] por_last      = cnt_nbits'(p_por_cycles - 1);
    localparam logic [cnt_nbits-1:0] debounce_last = cnt_nbits'(p_debounce_cycles - 1);
    localparam logic [cnt_nbits-1:0] pulse_last    = cnt_nbits'(p_pulse_cycles - 1);

    rst_gen_state_t        state;
    rst_gen_state_t        next_state;
    logic [cnt_nbits-1:0]  cnt;
    logic [cnt_nbits-1:0]  cnt_next;
    logic                  pulse_inc;
    logic                  btn_sync;

    btn_synchronizer u_btn_sync (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_sync (btn_sync)
    );

    always_comb begin
        next_state = state;
        cnt_next   = cnt + cnt_nbits'(1);
        pulse_inc  = 1'b0;
        case (state)
            POR: begin
                if (cnt == por_last) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end
            end
            IDLE: begin
                cnt_next = '0;
                if (btn_sync) begin
                    next_state = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!btn_sync) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else if (cnt == debounce_last) begin
                    next_state = PULSE;
                    cnt_next   = '0;
                    pulse_inc  = 1'b1;
                end
            end
            PULSE: begin
                if (cnt == pulse_last) begin
                    next_state = RELEASE;
                    cnt_next   = '0;
                end
            end
            RELEASE: begin
                // Any return of the button restarts the release qualification window.
                if (btn_sync) begin
                    cnt_next = '0;
                end else if (cnt == debounce_last) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                next_state = POR;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from next_state into flops, so they track state with no extra lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= POR;
            cnt         <= '0;
            pulse_count <= '0;
            reset_out   <= 1'b1;
            ready       <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            reset_out <= (next_state == POR) || (next_state == PULSE);
            ready     <= (next_state == IDLE);
            if (pulse_inc && (pulse_count != '1)) begin
                pulse_count <= pulse_count + p_cnt_nbits'(1);
            end
        end
    end

endmodule
